axi_lite_master_ctrl: RTL and testbench

AXI_LITE_MASTER_CTRL -- requirements
Module: axi_lite_master_ctrl

---
 rtl/axi_lite_master_ctrl_if.sv | 34 +++
 rtl/axi_lite_master_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_axi_lite_master_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_ctrl_if.sv
// AXI4-Lite bus bundle used between axi_lite_master_ctrl (master) and its slave.
// Carries the five channels. Clock and reset stay outside the bundle.
interface axi_lite_master_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns start pulses into one read or write.
// Optional response watchdog enabled by defining AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    master_start_read,
  input  logic                    master_start_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]              resp,
  output logic                    timeout,
  axi_lite_master_ctrl_if.master  axi
);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic                    awvalid_reg, awvalid_next;
  logic                    wvalid_reg, wvalid_next;
  logic                    arvalid_reg, arvalid_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]       wstrb_reg, wstrb_next;
  logic [DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;
  logic [1:0]              resp_reg, resp_next;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;
  logic             waiting;
`endif

  always_comb begin
    state_next   = state_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    arvalid_next = arvalid_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    rd_data_next = rd_data_reg;
    resp_next    = resp_reg;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    timeout_next = timeout_reg;
    cnt_next     = cnt_reg;
    waiting      = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (master_start_write || master_start_read) begin
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          wstrb_next = cmd_wstrb;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
          timeout_next = 1'b0;
          cnt_next     = '0;
`endif
          // Write has priority; a simultaneous read request is simply dropped.
          if (master_start_write) begin
            state_next   = WR_REQ;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = RD_REQ;
            arvalid_next = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // A cleared valid in this state means that channel already handshook.
        if (awvalid_reg && axi.awready) awvalid_next = 1'b0;
        if (wvalid_reg && axi.wready)   wvalid_next  = 1'b0;
        if ((!awvalid_reg || axi.awready) && (!wvalid_reg || axi.wready))
          state_next = WR_RESP;
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          resp_next  = axi.bresp;
          state_next = DONE;
        end
      end
      RD_REQ: begin
        if (axi.arready) begin
          arvalid_next = 1'b0;
          state_next   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (axi.rvalid) begin
          resp_next    = axi.rresp;
          rd_data_next = axi.rdata;
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    waiting = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
              (state_reg == RD_REQ) || (state_reg == RD_RESP);
    if (waiting) begin
      cnt_next = cnt_reg + 1'b1;
      // A response arriving on the final cycle still completes normally.
      if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1) && state_next != DONE) begin
        state_next   = DONE;
        awvalid_next = 1'b0;
        wvalid_next  = 1'b0;
        arvalid_next = 1'b0;
        resp_next    = 2'b10;
        timeout_next = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rd_data_reg <= '0;
      resp_reg    <= 2'b00;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      arvalid_reg <= arvalid_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      rd_data_reg <= rd_data_next;
      resp_reg    <= resp_next;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
`endif
    end
  end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign rd_data     = rd_data_reg;
  assign resp        = resp_reg;
  assign axi.awaddr  = addr_reg;
  assign axi.araddr  = addr_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.wstrb   = wstrb_reg;
  assign axi.awvalid = awvalid_reg;
  assign axi.wvalid  = wvalid_reg;
  assign axi.arvalid = arvalid_reg;
  assign axi.bready  = (state_reg == WR_RESP);
  assign axi.rready  = (state_reg == RD_RESP);
endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Directed bench for axi_lite_master_ctrl; inputs change and outputs are checked 1ns after each rising edge.
// The watchdog case follows whether AXI_LITE_MASTER_TIMEOUT_EN is defined for the build.
module tb_axi_lite_master_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_rd, start_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          busy, done, timeout;
  logic [DW-1:0] rd_data;
  logic [1:0]    resp;
  int            n_vec = 0;
  int            n_err = 0;

  axi_lite_master_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_lite_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .master_start_read(start_rd), .master_start_write(start_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .busy(busy), .done(done), .rd_data(rd_data), .resp(resp), .timeout(timeout),
    .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start_rd = 0; start_wr = 0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
    axi.arready = 0; axi.rvalid = 0; axi.rresp = 2'b00; axi.rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_resp", resp, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_awaddr", axi.awaddr, 0);

    // Write, slave ready at once, bvalid two cycles after bready rises: done in cycle 5.
    cmd_addr = 32'h1000; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
    start_wr = 1; axi.awready = 1; axi.wready = 1;
    tick(); start_wr = 0;
    chk("w1_awvalid", axi.awvalid, 1);
    chk("w1_wvalid", axi.wvalid, 1);
    chk("w1_awaddr", axi.awaddr, 32'h1000);
    chk("w1_wdata", axi.wdata, 32'h1234_5678);
    chk("w1_wstrb", axi.wstrb, 4'hF);
    chk("w1_busy", busy, 1);
    tick(); axi.awready = 0; axi.wready = 0;
    chk("w1_awvalid_drop", axi.awvalid, 0);
    chk("w1_wvalid_drop", axi.wvalid, 0);
    chk("w1_bready", axi.bready, 1);
    tick();
    chk("w1_done_early", done, 0);
    tick(); axi.bvalid = 1; axi.bresp = 2'b00;
    chk("w1_done_early2", done, 0);
    tick(); axi.bvalid = 0;
    chk("w1_done", done, 1);
    chk("w1_resp", resp, 2'b00);
    chk("w1_bready_off", axi.bready, 0);
    tick();
    chk("w1_done_pulse", done, 0);
    chk("w1_idle", busy, 0);

    // Write with W accepted three cycles before AW; read start during busy ignored.
    cmd_addr = 32'h2000; cmd_wdata = 32'hA5A5_A5A5; cmd_wstrb = 4'h3;
    start_wr = 1; axi.wready = 1;
    tick(); start_wr = 0;
    chk("w2_awvalid", axi.awvalid, 1);
    chk("w2_wvalid", axi.wvalid, 1);
    tick(); axi.wready = 0; start_rd = 1; cmd_addr = 32'h9999;
    chk("w2_wvalid_drop", axi.wvalid, 0);
    chk("w2_awvalid_hold", axi.awvalid, 1);
    chk("w2_bready_wait", axi.bready, 0);
    tick(); start_rd = 0;
    chk("w2_awvalid_hold2", axi.awvalid, 1);
    chk("w2_no_arvalid", axi.arvalid, 0);
    chk("w2_awaddr_kept", axi.awaddr, 32'h2000);
    tick(); axi.awready = 1;
    chk("w2_awvalid_hold3", axi.awvalid, 1);
    tick(); axi.awready = 0; axi.bvalid = 1; axi.bresp = 2'b01;
    chk("w2_awvalid_drop", axi.awvalid, 0);
    chk("w2_bready", axi.bready, 1);
    tick(); axi.bvalid = 0;
    chk("w2_done", done, 1);
    chk("w2_resp", resp, 2'b01);
    tick();
    chk("w2_single_done", done, 0);
    chk("w2_no_read_after", busy, 0);

    // Read of 0x10 returning DEADBEEF two cycles after the AR handshake.
    cmd_addr = 32'h10; start_rd = 1;
    tick(); start_rd = 0;
    chk("r_arvalid", axi.arvalid, 1);
    chk("r_araddr", axi.araddr, 32'h10);
    chk("r_no_awvalid", axi.awvalid, 0);
    chk("r_rready_early", axi.rready, 0);
    axi.arready = 1;
    tick(); axi.arready = 0;
    chk("r_arvalid_drop", axi.arvalid, 0);
    chk("r_rready", axi.rready, 1);
    tick(); axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF; axi.rresp = 2'b00;
    chk("r_done_early", done, 0);
    tick(); axi.rvalid = 0; axi.rdata = '0;
    chk("r_done", done, 1);
    chk("r_rd_data", rd_data, 32'hDEAD_BEEF);
    chk("r_resp", resp, 2'b00);
    tick();
    chk("r_done_pulse", done, 0);
    chk("r_rd_data_hold", rd_data, 32'hDEAD_BEEF);

    // Stray bvalid in IDLE must not disturb anything.
    axi.bvalid = 1; axi.bresp = 2'b11;
    tick(); axi.bvalid = 0;
    chk("stray_b_resp", resp, 2'b00);
    chk("stray_b_done", done, 0);

    // Simultaneous starts: write wins. Then reset while awvalid is high.
    cmd_addr = 32'h30; start_rd = 1; start_wr = 1;
    tick(); start_rd = 0; start_wr = 0;
    chk("both_awvalid", axi.awvalid, 1);
    chk("both_wvalid", axi.wvalid, 1);
    chk("both_arvalid", axi.arvalid, 0);
    rst = 1;
    tick(); rst = 0;
    chk("abort_awvalid", axi.awvalid, 0);
    chk("abort_wvalid", axi.wvalid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_data", rd_data, 0);
    tick();
    chk("abort_no_done", done, 0);

    // Write whose response never arrives.
    cmd_addr = 32'h40; cmd_wdata = 32'h55; cmd_wstrb = 4'h1;
    start_wr = 1; axi.awready = 1; axi.wready = 1;
    tick(); start_wr = 0;
    tick(); axi.awready = 0; axi.wready = 0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    for (int i = 2; i <= TO; i++) begin
      chk($sformatf("to_wait_done_c%0d", i), done, 0);
      tick();
    end
    chk("to_done", done, 1);
    chk("to_timeout", timeout, 1);
    chk("to_resp", resp, 2'b10);
    chk("to_bready_off", axi.bready, 0);
    chk("to_rd_data_kept", rd_data, 0);
    tick();
    chk("to_idle", busy, 0);
    chk("to_timeout_hold", timeout, 1);
    cmd_addr = 32'h50; start_rd = 1;
    tick(); start_rd = 0;
    chk("to_cleared", timeout, 0);
    axi.arready = 1;
    tick(); axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h0BAD_F00D; axi.rresp = 2'b00;
    tick(); axi.rvalid = 0;
    chk("to_next_read_done", done, 1);
    chk("to_next_read_data", rd_data, 32'h0BAD_F00D);
`else
    for (int i = 2; i <= 3 * TO; i++) begin
      chk($sformatf("nto_busy_c%0d", i), busy, 1);
      chk($sformatf("nto_done_c%0d", i), done, 0);
      tick();
    end
    chk("nto_timeout", timeout, 0);
    axi.bvalid = 1; axi.bresp = 2'b00;
    tick(); axi.bvalid = 0;
    chk("nto_late_done", done, 1);
    chk("nto_late_timeout", timeout, 0);
    tick();
    chk("nto_idle", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
